// File: rtl/stepper_motion_ctrl_if.sv
// Command channel between a host-side decoder and one stepper motion
// sequencer.
//   cmd_valid  host offers a move command
//   cmd_ready  sequencer can take a command this cycle
//   cmd_steps  number of rotate pulses to emit (0 = report done only)
//   cmd_dir    1 = forward, 0 = reverse
interface stepper_motion_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;

  modport master (output cmd_valid, cmd_steps, cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, cmd_steps, cmd_dir, output cmd_ready);
endinterface

// File: rtl/stepper_motion_ctrl.sv
// Motion sequencer for one stepper driver channel. It accepts move
// commands, emits a symmetric linear-ramp (trapezoidal) pulse train, and
// then holds reduced current before releasing the driver.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   cmd            command channel (slave side)
//   abort          stop the current move; it enters HOLD on the next cycle
//   rotate_pulse   registered step pulse, PULSE_WIDTH clocks high
//   direction      direction latched from the accepted command
//   module_enable  driver standby release (SETTLE, RUN, HOLD)
//   vref_level     current-limit level: RUN_VREF / HOLD_VREF / 0
//   busy           sequencer not idle
//   done           one-cycle pulse at the end of every move
//   position       signed pulse position, wraps modulo 2^16
module stepper_motion_ctrl #(
  parameter logic [15:0] START_PERIOD  = 16'd100,
  parameter logic [15:0] MIN_PERIOD    = 16'd60,
  parameter logic [15:0] ACCEL_DELTA   = 16'd10,
  parameter logic [15:0] PULSE_WIDTH   = 16'd4,
  parameter logic [15:0] SETTLE_CYCLES = 16'd8,
  parameter logic [15:0] HOLD_CYCLES   = 16'd50,
  parameter logic [3:0]  RUN_VREF      = 4'd12,
  parameter logic [3:0]  HOLD_VREF     = 4'd4
) (
  input  logic                        clk,
  input  logic                        rst,
  stepper_motion_ctrl_if.slave        cmd,
  input  logic                        abort,
  output logic                        rotate_pulse,
  output logic                        direction,
  output logic                        module_enable,
  output logic [3:0]                  vref_level,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 position
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] period_q, period_d;
  logic [15:0] ramp_cnt_q, ramp_cnt_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] position_q, position_d;
  logic        dir_q, dir_d;
  logic        pulse_q, pulse_d;
  logic        done_q, done_d;

  logic        ready;
  logic        xfer;
  logic [15:0] rem_dec;
  logic [16:0] period_up;
  logic [16:0] accel_floor;

  assign ready         = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign cmd.cmd_ready = ready;
  assign xfer          = cmd.cmd_valid && ready;
  assign rem_dec       = remaining_q - 16'd1;
  // 17-bit sums keep the saturating ramp free of wrap-around.
  assign period_up     = {1'b0, period_q} + {1'b0, ACCEL_DELTA};
  assign accel_floor   = {1'b0, MIN_PERIOD} + {1'b0, ACCEL_DELTA};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    ramp_cnt_d  = ramp_cnt_q;
    remaining_d = remaining_q;
    position_d  = position_q;
    dir_d       = dir_q;
    pulse_d     = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (state_q == S_HOLD) begin
          if (timer_q == HOLD_CYCLES - 16'd1) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        // A transfer overrides the hold countdown; abort is ignored here.
        if (xfer) begin
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_SETTLE;
            timer_d     = '0;
            dir_d       = cmd.cmd_dir;
            remaining_d = cmd.cmd_steps;
            period_d    = START_PERIOD;
            ramp_cnt_d  = '0;
          end
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d     = S_HOLD;
          timer_d     = '0;
          remaining_d = '0;
          done_d      = 1'b1;
        end else if (timer_q == SETTLE_CYCLES - 16'd1) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d     = S_HOLD;
          timer_d     = '0;
          remaining_d = '0;
          done_d      = 1'b1;
        end else begin
          pulse_d = (timer_q < PULSE_WIDTH);
          // Count the pulse on the edge where rotate_pulse rises.
          if (timer_q == '0) begin
            position_d = dir_q ? position_q + 16'd1 : position_q - 16'd1;
          end
          if (timer_q == period_q - 16'd1) begin
            timer_d     = '0;
            remaining_d = rem_dec;
            if (rem_dec == '0) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end else if (rem_dec <= ramp_cnt_q) begin
              period_d   = (period_up > {1'b0, START_PERIOD}) ? START_PERIOD : period_up[15:0];
              ramp_cnt_d = (ramp_cnt_q == '0) ? '0 : ramp_cnt_q - 16'd1;
            end else if (period_q > MIN_PERIOD) begin
              period_d   = ({1'b0, period_q} >= accel_floor) ? period_q - ACCEL_DELTA : MIN_PERIOD;
              ramp_cnt_d = ramp_cnt_q + 16'd1;
            end
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      period_q    <= START_PERIOD;
      ramp_cnt_q  <= '0;
      remaining_q <= '0;
      position_q  <= '0;
      dir_q       <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      ramp_cnt_q  <= ramp_cnt_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      dir_q       <= dir_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  assign rotate_pulse  = pulse_q;
  assign direction     = dir_q;
  assign done          = done_q;
  assign position      = position_q;
  assign busy          = (state_q != S_IDLE);
  assign module_enable = (state_q != S_IDLE);

  always_comb begin
    vref_level = '0;
    case (state_q)
      S_SETTLE, S_RUN: vref_level = RUN_VREF;
      S_HOLD:          vref_level = HOLD_VREF;
      default:         vref_level = '0;
    endcase
  end

endmodule

// File: doc/stepper_motion_ctrl.md
Name: stepper_motion_ctrl

Overview:
- Motion sequencer for one stepper driver channel. It drives that channel's rotate_pulse, direction, module_enable and vref_level inputs.
- Accepts move commands (pulse count plus direction) over a valid/ready handshake.
- Produces a symmetric linear-ramp (trapezoidal) pulse train, then holds current at a reduced VREF level before disabling the driver.
- Sits between the command source (UART/host decoder) and the motor driver block; one instance per motor.

Parameters:
- START_PERIOD, 100, clocks per pulse at the start and end of a ramp; 16 bit, must be ≥ MIN_PERIOD.
- MIN_PERIOD, 60, clocks per pulse at cruise; must be > PULSE_WIDTH.
- ACCEL_DELTA, 10, period change per pulse while ramping.
- PULSE_WIDTH, 4, clocks rotate_pulse stays high per pulse.
- SETTLE_CYCLES, 8, clocks the driver is enabled before the first pulse.
- HOLD_CYCLES, 50, clocks of hold current after a move.
- RUN_VREF, 4'd12, vref_level during SETTLE and RUN.
- HOLD_VREF, 4'd4, vref_level during HOLD.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted.
- cmd_steps  in  16  number of rotate pulses to emit.
- cmd_dir  in  1  1 = forward.
- abort  in  1  stop the move immediately.
- rotate_pulse  out  1  step pulse to the driver.
- direction  out  1  latched cmd_dir.
- module_enable  out  1  driver standby release.
- vref_level  out  4  current-limit PWM level.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of a move (normal or aborted).
- position  out  16  signed pulse position; +1 per forward pulse, -1 per reverse pulse, wraps modulo 2^16.

Behaviour:
- Reset (async, any state): state IDLE. rotate_pulse, direction, module_enable, done, busy = 0; vref_level = 0; position = 0; period = START_PERIOD; ramp_cnt = 0; remaining = 0.
- cmd_ready is combinational: 1 in IDLE and HOLD, 0 otherwise. A transfer occurs on any clock edge where cmd_valid && cmd_ready.
- States:
  - IDLE → SETTLE on transfer with cmd_steps ≠ 0. Latch direction, set remaining = cmd_steps, period = START_PERIOD, ramp_cnt = 0.
  - Transfer with cmd_steps = 0: no state change, no enable change; done = 1 for the following cycle.
  - SETTLE: module_enable = 1, vref_level = RUN_VREF. Count SETTLE_CYCLES clocks, then go to RUN with timer = 0.
  - RUN: timer counts 0..period-1. rotate_pulse = 1 while timer < PULSE_WIDTH (registered). position updates on the cycle rotate_pulse rises.
  - RUN, at timer = period-1: remaining decrements.
    - If the new remaining = 0, go to HOLD.
    - Else if new remaining ≤ ramp_cnt: decelerate. period = min(period+ACCEL_DELTA, START_PERIOD); ramp_cnt decrements, saturating at 0.
    - Else if period > MIN_PERIOD: accelerate. period = max(period-ACCEL_DELTA, MIN_PERIOD); ramp_cnt increments.
    - Else cruise: no change.
  - HOLD: module_enable = 1, vref_level = HOLD_VREF, done = 1 on the first HOLD cycle only. After HOLD_CYCLES clocks go to IDLE (module_enable = 0, vref_level = 0).
  - A transfer in HOLD goes straight to SETTLE with new latches. HOLD counter is discarded. No extra done is issued.
- abort in SETTLE or RUN: next cycle enters HOLD, rotate_pulse forced 0, remaining cleared. A truncated high pulse still counts in position.
- abort in IDLE or HOLD is ignored. abort and a transfer on the same edge in HOLD: the transfer wins.
- First rotate_pulse rise is SETTLE_CYCLES+1 clocks after the accepting edge.
- direction is stable for the whole move and changes only on a transfer.
- Arithmetic: period and remaining are 16 bit. Ramp add/subtract saturates as specified, with no wrap.

Test Plan:
1. Reset mid-RUN (rst asserted while rotate_pulse = 1) → all outputs 0 asynchronously, cmd_ready = 1, position = 0.
2. Defaults, cmd_steps = 10, cmd_dir = 1 → pulse periods exactly 100, 90, 80, 70, 60, 60, 70, 80, 90, 100 clocks, each pulse high for 4 clocks. position ends at 10. done one cycle on HOLD entry. module_enable drops 50 clocks later; vref_level 12 → 4 → 0.
3. cmd_steps = 3, cmd_dir = 0 → periods 100, 90, 100 (the ramp never reaches MIN_PERIOD). position = -3. direction = 0 throughout.
4. abort on the 5th pulse's second high cycle → rotate_pulse low the next cycle, HOLD entered, done pulses once, position = 5.
5. New command (cmd_steps = 2) offered while in HOLD → accepted that edge, SETTLE restarts, enable stays high continuously, exactly one done per move.
6. cmd_steps = 0 → done pulses once the next cycle; module_enable never rises; busy stays 0.
